register: RTL and testbench

- General-purpose register file for the datapath: 32 entries of 32 bits each.
- One synchronous write port and two independent combinational read ports (A and B).
- Sits between the instruction decode stage and the ALU.
- Supplies two operands per cycle and accepts one result per cycle.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_read_port.sv | 24 ++
 rtl/register.sv | 63 ++++++
 tb/tb_register.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the datapath register file.
//   DATA_W     : width of each register and of the data ports
//   ADDR_W     : width of each address port
//   DEPTH      : number of architectural registers (entry 0 is hardwired to zero)
//   reg_data_t : one register word
//   reg_addr_t : one register address
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational read port of the register file.
//   regs_i : stored contents of registers 1..DEPTH-1 (register 0 has no storage)
//   addr_i : read address
//   data_o : regs_i[addr_i], or zero when addr_i is 0
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_data_t regs_i [1:DEPTH-1],
  input  reg_addr_t addr_i,
  output reg_data_t data_o
);

  // Compare-and-select over every stored entry; address 0 matches none and
  // falls through to the zero default.
  always_comb begin
    data_o = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (addr_i == reg_addr_t'(i)) begin
        data_o = regs_i[i];
      end
    end
  end

endmodule

// File: rtl/register.sv
// Datapath register file: 32 x 32 bits, one synchronous write port and two
// independent combinational read ports. Register 0 always reads zero.
//   Clock  : system clock, writes on rising edge
//   Reset  : asynchronous active-high clear of every register
//   EnWri  : write enable
//   WriAdd : write address
//   DataI  : write data
//   ReadA  : port A read address      DataA : port A read data
//   ReadB  : port B read address      DataB : port B read data
module register
  import regfile_pkg::*;
(
  input  logic      Clock,
  input  logic      Reset,
  input  logic      EnWri,
  input  reg_addr_t WriAdd,
  input  reg_data_t DataI,
  input  reg_addr_t ReadA,
  input  reg_addr_t ReadB,
  output reg_data_t DataA,
  output reg_data_t DataB
);

  // Register 0 is hardwired to zero, so only entries 1..DEPTH-1 hold state.
  reg_data_t regs_q [1:DEPTH-1];
  reg_data_t regs_d [1:DEPTH-1];

  // Only an explicit 1 on EnWri writes; X/Z falls through to "hold".
  always_comb begin
    for (int unsigned i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if ((EnWri === 1'b1) && (WriAdd == reg_addr_t'(i))) begin
        regs_d[i] = DataI;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write bypass: reads see stored contents only.
  regfile_read_port u_read_a (
    .regs_i (regs_q),
    .addr_i (ReadA),
    .data_o (DataA)
  );

  regfile_read_port u_read_b (
    .regs_i (regs_q),
    .addr_i (ReadB),
    .data_o (DataB)
  );

endmodule

// File: tb/tb_register.sv
// Directed self-checking bench for the register file.
module tb_register;
  import regfile_pkg::*;

  logic      Clock;
  logic      Reset;
  logic      EnWri;
  reg_addr_t WriAdd;
  reg_data_t DataI;
  reg_addr_t ReadA;
  reg_addr_t ReadB;
  reg_data_t DataA;
  reg_data_t DataB;

  int errors = 0;
  int checks = 0;

  register dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .EnWri  (EnWri),
    .WriAdd (WriAdd),
    .DataI  (DataI),
    .ReadA  (ReadA),
    .ReadB  (ReadB),
    .DataA  (DataA),
    .DataB  (DataB)
  );

  // Rising edges at 5, 15, 25, ...
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input reg_data_t obs, input reg_data_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a write during the low phase, let one rising edge commit it.
  task automatic write_reg(input reg_addr_t addr, input reg_data_t data);
    @(negedge Clock);
    EnWri  = 1'b1;
    WriAdd = addr;
    DataI  = data;
    @(negedge Clock);
    EnWri  = 1'b0;
  endtask

  initial begin
    Reset  = 1'b1;
    EnWri  = 1'b0;
    WriAdd = '0;
    DataI  = '0;
    ReadA  = '0;
    ReadB  = '0;

    // Reset: every address reads zero on both ports, even across an edge
    // with a write attempted.
    #2;
    EnWri  = 1'b1;
    WriAdd = 5'd4;
    DataI  = 32'hFFFF_FFFF;
    @(posedge Clock);
    #1;
    EnWri = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ReadA = reg_addr_t'(a);
      ReadB = reg_addr_t'(31 - a);
      #1;
      check($sformatf("reset_a[%0d]", a), DataA, 32'h0);
      check($sformatf("reset_b[%0d]", 31 - a), DataB, 32'h0);
    end
    @(negedge Clock);
    Reset = 1'b0;

    // Basic write / read.
    write_reg(5'd3, 32'h0000_000F);
    ReadA = 5'd3;
    ReadB = 5'd3;
    #1;
    check("basic_a", DataA, 32'h0000_000F);
    check("basic_b", DataB, 32'h0000_000F);

    // Sweep: reg k = 5*k.
    for (int k = 1; k < 32; k++) begin
      write_reg(reg_addr_t'(k), reg_data_t'(5 * k));
    end
    for (int k = 1; k < 32; k++) begin
      ReadA = reg_addr_t'(k);
      ReadB = reg_addr_t'(31 - k);
      #1;
      check($sformatf("sweep_a[%0d]", k), DataA, reg_data_t'(5 * k));
      check($sformatf("sweep_b[%0d]", 31 - k), DataB, reg_data_t'(5 * (31 - k)));
    end
    ReadA = 5'd0;
    #1;
    check("sweep_a[0]", DataA, 32'h0);

    // Enable off: three edges with EnWri low must not disturb reg 7.
    write_reg(5'd7, 32'hDEAD_BEEF);
    @(negedge Clock);
    EnWri  = 1'b0;
    WriAdd = 5'd7;
    DataI  = 32'h1234_5678;
    repeat (3) @(posedge Clock);
    #1;
    ReadA = 5'd7;
    ReadB = 5'd6;
    #1;
    check("en_off_r7", DataA, 32'hDEAD_BEEF);
    check("en_off_r6", DataB, 32'd30);

    // Register 0 discards writes.
    write_reg(5'd0, 32'h0000_0005);
    ReadA = 5'd0;
    ReadB = 5'd0;
    #1;
    check("r0_a", DataA, 32'h0);
    check("r0_b", DataB, 32'h0);

    // Read-during-write: old value before the edge, new value after it.
    write_reg(5'd9, 32'h0000_000A);
    @(negedge Clock);
    ReadA  = 5'd9;
    ReadB  = 5'd9;
    WriAdd = 5'd9;
    DataI  = 32'h0000_000B;
    EnWri  = 1'b1;
    #1;
    check("rdw_before", DataA, 32'h0000_000A);
    @(posedge Clock);
    #1;
    check("rdw_after_a", DataA, 32'h0000_000B);
    check("rdw_after_b", DataB, 32'h0000_000B);
    EnWri = 1'b0;

    // Async reset mid-cycle: outputs clear without a clock edge.
    #1;
    ReadB = 5'd7;
    #1;
    check("pre_reset_r7", DataB, 32'hDEAD_BEEF);
    Reset = 1'b1;
    #1;
    check("async_reset_a", DataA, 32'h0);
    check("async_reset_b", DataB, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;

    // Writes work again after reset is released.
    write_reg(5'd9, 32'h0000_0C0C);
    ReadA = 5'd9;
    ReadB = 5'd5;
    #1;
    check("post_reset_write", DataA, 32'h0000_0C0C);
    check("post_reset_r5", DataB, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
